// File: rtl/ws2812_chain_if.sv
// Write/start/status bundle between upstream colour logic and the WS2812 chain driver.
// The master side writes colours and requests frames; the slave side is the driver.
interface ws2812_chain_if #(
  parameter int ADDR_W = 3
);
  logic              i_Wr_En;
  logic [ADDR_W-1:0] i_Wr_Addr;
  logic [23:0]       i_Wr_Data;
  logic              i_Start;
  logic              o_Led;
  logic              o_Ready;
  logic              o_Frame_Done;

  modport master (
    output i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
    input  o_Led, o_Ready, o_Frame_Done
  );

  modport slave (
    input  i_Wr_En, i_Wr_Addr, i_Wr_Data, i_Start,
    output o_Led, o_Ready, o_Frame_Done
  );
endinterface

// File: rtl/ws2812_chain.sv
// Serialises a NUM_LEDS-deep GRB frame buffer onto a WS2812 daisy chain, one frame
// per start request or back-to-back when AUTO_REFRESH is set.
module ws2812_chain #(
  parameter int NUM_LEDS     = 8,
  parameter int ADDR_W       = 3,
  parameter int T0H_CYC      = 17,
  parameter int T1H_CYC      = 34,
  parameter int BIT_CYC      = 60,
  parameter int RESET_CYC    = 2880,
  parameter int AUTO_REFRESH = 0
) (
  input  logic           i_Clock,
  input  logic           i_Reset,
  ws2812_chain_if.slave  bus
);

  localparam int CNT_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [CNT_W-1:0]  T0H_LAST   = CNT_W'(T0H_CYC - 1);
  localparam logic [CNT_W-1:0]  T1H_LAST   = CNT_W'(T1H_CYC - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(RESET_CYC);
  localparam logic [ADDR_W-1:0] LAST_LED   = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W:0]   NUM_LEDS_W = (ADDR_W + 1)'(NUM_LEDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        bit_q, bit_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [23:0]       shift_q, shift_d;
  logic              led_q, led_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [23:0]       mem_q [DEPTH];
  logic [23:0]       mem_d [DEPTH];

  // Entries at or above NUM_LEDS are never written and stay zero.
  always_comb begin
    mem_d = mem_q;
    if (bus.i_Wr_En && ({1'b0, bus.i_Wr_Addr} < NUM_LEDS_W)) begin
      mem_d[bus.i_Wr_Addr] = bus.i_Wr_Data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (bus.i_Start || (AUTO_REFRESH != 0)) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Reading mem_d lets a same-edge write to this LED win over the stale entry.
        shift_d = mem_d[idx_q];
        bit_d   = 5'd23;
        cnt_d   = '0;
        state_d = S_HIGH;
      end
      S_HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == (shift_q[23] ? T1H_LAST : T0H_LAST)) begin
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 5'd1;
            state_d = S_HIGH;
          end else if (idx_q != LAST_LED) begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_LOAD;
          end else begin
            state_d = S_LATCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // The wire lags the state by one cycle, keeping o_Led a plain register.
    led_d   = (state_q == S_HIGH);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      led_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      led_q   <= led_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.o_Led        = led_q;
  assign bus.o_Ready      = ready_q;
  assign bus.o_Frame_Done = done_q;

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench for ws2812_chain: decodes the serial wire back into bits and checks
// timing, start handling, write visibility, reset abort and auto-refresh spacing.
module tb_ws2812_chain;

  localparam int T0H   = 17;
  localparam int T1H   = 34;
  localparam int BITC  = 60;
  localparam int RSTC  = 2880;
  // auto-refresh instance: 2 LEDs, short timings -> 2*(24*6+1)+10+2
  localparam int A_PERIOD = 302;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arst = 1'b1;
  int   cyc = 0;
  int   done_cnt = 0;
  int   total = 0;
  int   bad = 0;
  bit   auto_fin = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (m_if.o_Frame_Done === 1'b1) done_cnt <= done_cnt + 1;

  ws2812_chain_if #(.ADDR_W(3)) m_if ();
  ws2812_chain_if #(.ADDR_W(1)) a_if ();

  ws2812_chain #(
    .NUM_LEDS(2), .ADDR_W(3), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .BIT_CYC(BITC), .RESET_CYC(RSTC), .AUTO_REFRESH(0)
  ) u_dut (
    .i_Clock(clk), .i_Reset(rst), .bus(m_if)
  );

  ws2812_chain #(
    .NUM_LEDS(2), .ADDR_W(1), .T0H_CYC(2), .T1H_CYC(4),
    .BIT_CYC(6), .RESET_CYC(10), .AUTO_REFRESH(1)
  ) u_auto (
    .i_Clock(clk), .i_Reset(arst), .bus(a_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [23:0] data);
    m_if.i_Wr_En   = 1'b1;
    m_if.i_Wr_Addr = addr;
    m_if.i_Wr_Data = data;
    @(negedge clk);
    m_if.i_Wr_En   = 1'b0;
    $display("write addr=%0d data=%06h", addr, data);
  endtask

  // Called at a negedge; returns at the first negedge where o_Led is high.
  task automatic start_frame();
    chk("ready_before_start", m_if.o_Ready, 1);
    m_if.i_Start = 1'b1;
    @(negedge clk);
    m_if.i_Start = 1'b0;
    chk("ready_drop", m_if.o_Ready, 0);
    chk("led_edge1", m_if.o_Led, 0);
    @(negedge clk);
    chk("led_edge1b", m_if.o_Led, 0);
    @(negedge clk);
    chk("led_edge2", m_if.o_Led, 1);
  endtask

  task automatic frame_check(input string tag, input logic [47:0] exp);
    logic [47:0] bits;
    int w, g, w0, w1, badw, lowc, exp_low;
    int r0, r1, r23, r24;
    bits = '0; w0 = 0; w1 = 0; badw = 0; lowc = 0;
    r0 = 0; r1 = 0; r23 = 0; r24 = 0;
    for (int b = 0; b < 48; b++) begin
      g = 0;
      while (m_if.o_Led !== 1'b1 && g < 200) begin
        @(negedge clk);
        g++;
      end
      if (g >= 200) begin
        badw++;
        break;
      end
      if (b == 0) r0 = cyc;
      if (b == 1) r1 = cyc;
      if (b == 23) r23 = cyc;
      if (b == 24) r24 = cyc;
      w = 0;
      while (m_if.o_Led === 1'b1 && w < 200) begin
        w++;
        @(negedge clk);
      end
      if (b == 0) w0 = w;
      if (b == 1) w1 = w;
      bits[47-b] = (w == T1H);
      if (w != T0H && w != T1H) badw++;
    end
    while (m_if.o_Frame_Done !== 1'b1 && lowc < 6000) begin
      if (m_if.o_Led !== 1'b0) badw++;
      @(negedge clk);
      lowc++;
    end
    exp_low = BITC - (exp[0] ? T1H : T0H) + RSTC;
    $display("frame %s bits=%012h low_before_done=%0d", tag, bits, lowc);
    chk({tag, "_bits"}, bits, exp);
    chk({tag, "_width_err"}, badw, 0);
    chk({tag, "_w0"}, w0, exp[47] ? T1H : T0H);
    chk({tag, "_w1"}, w1, exp[46] ? T1H : T0H);
    chk({tag, "_period"}, r1 - r0, BITC);
    chk({tag, "_led_gap"}, r24 - r23, BITC + 1);
    chk({tag, "_latch_low"}, lowc, exp_low);
    @(negedge clk);
    chk({tag, "_done_pulse"}, m_if.o_Frame_Done, 0);
    chk({tag, "_ready_after"}, m_if.o_Ready, 1);
  endtask

  // Auto-refresh instance: consecutive o_Frame_Done pulses must be A_PERIOD apart.
  initial begin
    int t [4];
    int g;
    a_if.i_Wr_En = 1'b0; a_if.i_Wr_Addr = '0; a_if.i_Wr_Data = '0; a_if.i_Start = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = 0;
      while (a_if.o_Frame_Done !== 1'b1 && g < 1000) begin
        @(negedge clk);
        g++;
      end
      chk("auto_done_timeout", (g >= 1000), 0);
      t[k] = cyc;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      $display("auto frame spacing=%0d", t[k+1] - t[k]);
      chk("auto_spacing", t[k+1] - t[k], A_PERIOD);
    end
    auto_fin = 1'b1;
  end

  initial begin
    int d0, ledmax, rdymin, g;
    m_if.i_Wr_En = 1'b0; m_if.i_Wr_Addr = '0; m_if.i_Wr_Data = '0; m_if.i_Start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", m_if.o_Led, 0);
    chk("rst_ready", m_if.o_Ready, 1);
    chk("rst_done", m_if.o_Frame_Done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame: LED0 = 800001, LED1 = 0
    wr(3'd0, 24'h800001);
    wr(3'd1, 24'h000000);
    start_frame();
    frame_check("basic", 48'h800001_000000);

    // Start pulses during HIGH, LOW and LATCH are ignored
    d0 = done_cnt;
    start_frame();
    fork
      frame_check("ign_start", 48'h800001_000000);
      begin
        repeat (5) @(negedge clk);
        m_if.i_Start = 1'b1; @(negedge clk); m_if.i_Start = 1'b0;
        repeat (40) @(negedge clk);
        m_if.i_Start = 1'b1; @(negedge clk); m_if.i_Start = 1'b0;
        repeat (3500) @(negedge clk);
        m_if.i_Start = 1'b1; @(negedge clk); m_if.i_Start = 1'b0;
      end
    join
    chk("ign_one_done", done_cnt - d0, 1);
    ledmax = 0; rdymin = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_if.o_Led === 1'b1) ledmax = 1;
      if (m_if.o_Ready !== 1'b1) rdymin = 0;
    end
    chk("ign_no_second_led", ledmax, 0);
    chk("ign_ready_held", rdymin, 1);
    chk("ign_no_second_done", done_cnt - d0, 1);

    // Writes while LED0 shifts: LED1 new this frame, LED0 new next frame
    start_frame();
    fork
      frame_check("midwr", 48'h800001_FFFFFF);
      begin
        repeat (100) @(negedge clk);
        wr(3'd1, 24'hFFFFFF);
        wr(3'd0, 24'hFFFFFF);
      end
    join

    // Out-of-range addresses must not alias onto real LEDs
    wr(3'd2, 24'h123456);
    wr(3'd7, 24'hABCDEF);
    start_frame();
    frame_check("next_oor", 48'hFFFFFF_FFFFFF);

    // Reset during bit 10 of LED0
    start_frame();
    repeat (10 * BITC + 5) @(negedge clk);
    chk("abort_led_before", m_if.o_Led, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_led", m_if.o_Led, 0);
    chk("abort_ready", m_if.o_Ready, 1);
    chk("abort_done", m_if.o_Frame_Done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_frame();
    frame_check("post_rst", 48'h000000_000000);

    g = 0;
    while (!auto_fin && g < 20000) begin
      @(negedge clk);
      g++;
    end
    chk("auto_finished", auto_fin, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
